// File: rtl/gemm_pipe.sv
// Pipelined GEMM core: o[n] = acc[n] + sum_k i[k]*W[n][k], reduction split over
// BLOCK_IN/K_PER_STAGE register stages with a single global valid/ready stall.
module gemm_pipe #(
  parameter int unsigned INP_WIDTH   = 8,
  parameter int unsigned WGT_WIDTH   = 8,
  parameter int unsigned ACC_WIDTH   = 32,
  parameter int unsigned BLOCK_IN    = 16,
  parameter int unsigned BLOCK_OUT   = 16,
  parameter int unsigned K_PER_STAGE = 4,
  parameter int unsigned TAG_WIDTH   = 8
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     i_valid,
  output logic                                     i_ready,
  input  logic                                     i_zero_acc,
  input  logic [TAG_WIDTH-1:0]                     i_tag,
  input  logic [INP_WIDTH*BLOCK_IN-1:0]            i_tensor,
  input  logic [WGT_WIDTH*BLOCK_IN*BLOCK_OUT-1:0]  w_tensor,
  input  logic [ACC_WIDTH*BLOCK_OUT-1:0]           a_tensor,
  output logic                                     o_valid,
  input  logic                                     o_ready,
  output logic [TAG_WIDTH-1:0]                     o_tag,
  output logic [ACC_WIDTH*BLOCK_OUT-1:0]           o_tensor
);

  localparam int unsigned NUM_STAGES = BLOCK_IN / K_PER_STAGE;
  localparam int unsigned PROD_WIDTH = INP_WIDTH + WGT_WIDTH;
  localparam int unsigned IT_WIDTH   = INP_WIDTH * BLOCK_IN;
  localparam int unsigned WT_WIDTH   = WGT_WIDTH * BLOCK_IN * BLOCK_OUT;
  localparam int unsigned AT_WIDTH   = ACC_WIDTH * BLOCK_OUT;

  if (BLOCK_IN % K_PER_STAGE != 0) begin : g_bad_cfg
    $error("gemm_pipe: BLOCK_IN must be a multiple of K_PER_STAGE");
  end

  // Stage s holds operands feeding stage s+1; r_part/r_tag/r_vld[NUM_STAGES] is the output stage.
  logic [IT_WIDTH-1:0]  r_inp  [NUM_STAGES];
  logic [WT_WIDTH-1:0]  r_wgt  [NUM_STAGES];
  logic [AT_WIDTH-1:0]  r_part [NUM_STAGES+1];
  logic [TAG_WIDTH-1:0] r_tag  [NUM_STAGES+1];
  logic [NUM_STAGES:0]  r_vld;
  logic [AT_WIDTH-1:0]  w_sum  [NUM_STAGES];
  logic                 w_adv;

  assign w_adv    = !r_vld[NUM_STAGES] || o_ready;
  assign i_ready  = rst_n && w_adv;
  assign o_valid  = r_vld[NUM_STAGES];
  assign o_tag    = r_tag[NUM_STAGES];
  assign o_tensor = r_part[NUM_STAGES];

  // Partial sum produced by stage s+1: adds its K_PER_STAGE terms, wrapping modulo 2^ACC_WIDTH.
  always_comb begin : p_stage_sum
    logic signed [PROD_WIDTH-1:0] v_prod;
    logic [ACC_WIDTH-1:0]         v_acc;
    int unsigned                  v_k;
    v_prod = '0;
    v_acc  = '0;
    v_k    = 0;
    for (int unsigned s = 0; s < NUM_STAGES; s++) begin
      w_sum[s] = '0;
    end
    for (int unsigned s = 0; s < NUM_STAGES; s++) begin
      for (int unsigned n = 0; n < BLOCK_OUT; n++) begin
        v_acc = r_part[s][n*ACC_WIDTH +: ACC_WIDTH];
        for (int unsigned k = 0; k < K_PER_STAGE; k++) begin
          v_k    = s * K_PER_STAGE + k;
          v_prod = $signed(r_inp[s][v_k*INP_WIDTH +: INP_WIDTH]) *
                   $signed(r_wgt[s][(n*BLOCK_IN + v_k)*WGT_WIDTH +: WGT_WIDTH]);
          v_acc  = v_acc + ACC_WIDTH'(v_prod);
        end
        w_sum[s][n*ACC_WIDTH +: ACC_WIDTH] = v_acc;
      end
    end
  end

  // Whole pipe advances together; holds everything while the output is stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld <= '0;
      for (int unsigned s = 0; s < NUM_STAGES; s++) begin
        r_inp[s] <= '0;
        r_wgt[s] <= '0;
      end
      for (int unsigned s = 0; s <= NUM_STAGES; s++) begin
        r_part[s] <= '0;
        r_tag[s]  <= '0;
      end
    end else if (w_adv) begin
      r_vld[0]  <= i_valid;
      r_tag[0]  <= i_tag;
      r_inp[0]  <= i_tensor;
      r_wgt[0]  <= w_tensor;
      r_part[0] <= i_zero_acc ? '0 : a_tensor;
      for (int unsigned s = 1; s < NUM_STAGES; s++) begin
        r_inp[s] <= r_inp[s-1];
        r_wgt[s] <= r_wgt[s-1];
      end
      for (int unsigned s = 1; s <= NUM_STAGES; s++) begin
        r_part[s] <= w_sum[s-1];
        r_tag[s]  <= r_tag[s-1];
        r_vld[s]  <= r_vld[s-1];
      end
    end
  end

endmodule
